// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the 5-stage MIPS core: forwarding-mux selects and
// the destination record carried alongside each in-flight instruction.
package mips_pipe_pkg;

  localparam int DST_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic [DST_W-1:0] dst;
  } dst_rec_t;

  // $0 is hardwired zero, so a record targeting it never produces a value
  function automatic logic is_writer(input logic v, input logic wr, input logic [DST_W-1:0] d);
    return v & wr & (d != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side fields into the hazard/forward unit and its control strobes out.
interface hazard_fwd_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
    input  stall, bubble, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_reg_write, id_mem_read, flush,
    output stall, bubble, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/fwd_cmp.sv
// Priority comparator for one ALU operand: the EX-stage producer beats MEM.
module fwd_cmp
  import mips_pipe_pkg::*;
(
  input  logic [DST_W-1:0] src,
  input  dst_rec_t         ex,
  input  dst_rec_t         mem,
  output logic [1:0]       sel
);

  wire unused_ld = ex.mem_read ^ mem.mem_read;

  always_comb begin
    sel = FWD_REG;
    if (is_writer(ex.valid, ex.reg_write, ex.dst) && (ex.dst == src))
      sel = FWD_MEM;
    else if (is_writer(mem.valid, mem.reg_write, mem.dst) && (mem.dst == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall/bubble detection, registered ALU forwarding selects and a
// saturating stall counter for the ID/EX boundary.
module hazard_fwd_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  hazard_fwd_unit_if.slave hf
);

  dst_rec_t ex_q, mem_q, wb_q, id_rec;
  logic [REG_AW-1:0] src_a, src_b;
  logic [1:0] sel_a, sel_b;
  logic [1:0] fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic hazard, stall_w, bubble_w;

  // WB is tracked for completeness only: the write-first register file
  // already covers a producer three ahead
  wire unused_wb = ^wb_q;

  assign src_a  = hf.id_rs;
  assign src_b  = hf.id_rt;
  assign id_rec = '{valid: hf.id_valid, reg_write: hf.id_reg_write,
                    mem_read: hf.id_mem_read, dst: hf.id_dst};

  assign hazard = hf.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.dst != '0) &
                  ((ex_q.dst == hf.id_rs) | (hf.id_uses_rt & (ex_q.dst == hf.id_rt)));
  // flush discards the dependent instruction, so it never counts as a stall
  assign stall_w  = hazard & ~hf.flush & ~rst;
  assign bubble_w = (stall_w | hf.flush) & ~rst;

  fwd_cmp u_cmp_a (.src(src_a), .ex(ex_q), .mem(mem_q), .sel(sel_a));
  fwd_cmp u_cmp_b (.src(src_b), .ex(ex_q), .mem(mem_q), .sel(sel_b));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
      cnt_q   <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (bubble_w) begin
        ex_q    <= '0;
        fwd_a_q <= FWD_REG;
        fwd_b_q <= FWD_REG;
      end else begin
        ex_q    <= id_rec;
        fwd_a_q <= sel_a;
        fwd_b_q <= hf.id_uses_rt ? sel_b : FWD_REG;
      end
      if (stall_w && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hf.stall     = stall_w;
  assign hf.bubble    = bubble_w;
  assign hf.fwd_a     = fwd_a_q;
  assign hf.fwd_b     = fwd_b_q;
  assign hf.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit; a narrow-counter twin shares the stimulus
// so counter saturation is reachable in a short run.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  hazard_fwd_unit_if #(.REG_AW(5), .CNT_W(4))  if2 ();

  hazard_fwd_unit #(.REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .hf(if1.slave));
  hazard_fwd_unit #(.REG_AW(5), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .hf(if2.slave));

  assign if2.id_valid     = if1.id_valid;
  assign if2.id_rs        = if1.id_rs;
  assign if2.id_rt        = if1.id_rt;
  assign if2.id_uses_rt   = if1.id_uses_rt;
  assign if2.id_dst       = if1.id_dst;
  assign if2.id_reg_write = if1.id_reg_write;
  assign if2.id_mem_read  = if1.id_mem_read;
  assign if2.flush        = if1.flush;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic [4:0] dst, input logic rw,
                       input logic mr, input logic fl);
    if1.id_valid     = v;
    if1.id_rs        = rs;
    if1.id_rt        = rt;
    if1.id_uses_rt   = ut;
    if1.id_dst       = dst;
    if1.id_reg_write = rw;
    if1.id_mem_read  = mr;
    if1.flush        = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    issue(1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rst_stall", if1.stall, 1'b0);
    chk("rst_bubble", if1.bubble, 1'b0);
    chk("rst_fwd_a", if1.fwd_a, 2'b00);
    chk("rst_fwd_b", if1.fwd_b, 2'b00);
    chk("rst_cnt", if1.stall_cnt, 16'd0);
    rst = 1'b0;
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("alu_alu_stall", if1.stall, 1'b0);
    tick();
    chk("alu_alu_fwd_a", if1.fwd_a, 2'b10);
    chk("alu_alu_fwd_b", if1.fwd_b, 2'b00);
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    nops(1);
    issue(1'b1, 5'd1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("gap1_fwd_b", if1.fwd_b, 2'b01);
    chk("gap1_fwd_a", if1.fwd_a, 2'b00);
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    nops(1);
    issue(1'b1, 5'd1, 5'd3, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("gap1_nort_fwd_b", if1.fwd_b, 2'b00);
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    nops(2);
    issue(1'b1, 5'd3, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("gap2_fwd_a", if1.fwd_a, 2'b00);
    chk("gap2_fwd_b", if1.fwd_b, 2'b00);
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd2, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    chk("nearest_fwd_a", if1.fwd_a, 2'b10);
    chk("nearest_fwd_b", if1.fwd_b, 2'b10);
    nops(2);

    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    chk("lw_issue_stall", if1.stall, 1'b0);
    tick();
    issue(1'b1, 5'd4, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", if1.stall, 1'b1);
    chk("lu_bubble", if1.bubble, 1'b1);
    chk("lu_cnt0", if1.stall_cnt, 16'd0);
    tick();
    chk("lu_cnt1", if1.stall_cnt, 16'd1);
    chk("lu_stall_gone", if1.stall, 1'b0);
    chk("lu_bubble_gone", if1.bubble, 1'b0);
    chk("lu_bubble_fwd_a", if1.fwd_a, 2'b00);
    tick();
    chk("lu_fwd_a", if1.fwd_a, 2'b01);
    chk("lu_fwd_b", if1.fwd_b, 2'b00);
    nops(2);

    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd4, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", if1.stall, 1'b0);
    chk("fl_bubble", if1.bubble, 1'b1);
    tick();
    chk("fl_cnt", if1.stall_cnt, 16'd1);
    issue(1'b1, 5'd6, 5'd6, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_no_fwd_a", if1.fwd_a, 2'b00);
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("r0_fwd_a", if1.fwd_a, 2'b00);
    chk("r0_fwd_b", if1.fwd_b, 2'b00);
    nops(2);
    issue(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("r0_lu_stall", if1.stall, 1'b0);
    nops(2);

    for (int i = 0; i < 20; i++) begin
      issue(1'b1, (i == 0) ? 5'd1 : ((i % 2) ? 5'd4 : 5'd5), 5'd0, 1'b0,
            (i % 2) ? 5'd5 : 5'd4, 1'b1, 1'b1, 1'b0);
      if (i > 0) begin
        chk("chain_stall", if1.stall, 1'b1);
        tick();
        chk("chain_release", if1.stall, 1'b0);
      end
      tick();
    end
    chk("chain_cnt16", if1.stall_cnt, 16'd20);
    chk("chain_cnt4_sat", if2.stall_cnt, 4'hF);
    nops(2);

    issue(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    issue(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    chk("pre_rst_fwd_a", if1.fwd_a, 2'b10);
    issue(1'b1, 5'd4, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_stall", if1.stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", if1.stall, 1'b0);
    chk("mid_rst_bubble", if1.bubble, 1'b0);
    chk("mid_rst_fwd_a", if1.fwd_a, 2'b00);
    chk("mid_rst_cnt", if1.stall_cnt, 16'd0);
    chk("mid_rst_cnt4", if2.stall_cnt, 4'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_stall", if1.stall, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
